if_fetch: RTL
=============

Name: if_fetch

Overview:
Instruction-fetch stage and IF/ID pipeline latch for the 5-stage MIPS pipeline. It owns the PC, issues instruction-memory requests, and latches fetched words plus PC/NPC for the decode stage, which feeds id_ex. It absorbs branch/jump redirects and load-use stalls, and it keeps the imem address stable across multi-cycle misses. A flush that arrives during a miss is remembered until the in-flight access completes.

Parameters:
PC_INIT, 32'h0000_0000, PC value after reset; bits [1:0] must be 0
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous active-high reset
ihit  in  1  imem access complete this cycle; iload valid
iload  in  32  instruction word from imem
imemREN  out  1  imem read request
imemaddr  out  32  imem address; held stable while imemREN=1 and ihit=0
stall  in  1  hazard unit: hold IF/ID and PC (load-use)
flush  in  1  control transfer resolved downstream; squash IF/ID
redirect_pc  in  32  target PC, valid when flush=1
ifid_instr  out  32  latched instruction
ifid_pc  out  32  PC of latched instruction
ifid_npc  out  32  ifid_pc+4
ifid_valid  out  1  latched instruction is real, not a bubble
fetch_halted  out  1  state==HALT

Behaviour:
- Reset (async, RST=1): PC=PC_INIT, pend_pc=0, state=RUN, ifid_instr/pc/npc=0, ifid_valid=0. imemREN is forced to 0 while RST=1. Reset mid-miss abandons the access; no pending state survives.
- All state updates happen on the rising edge of CLK. imemREN = (state!=HALT) && !RST.
- imemaddr = PC in every state. PC changes only on the transitions listed below, never during RUN or DROP with ihit=0, so the address stays stable for the duration of a miss.
- redirect_pc[1:0] is forced to 0 when loaded. PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- "bubble" means: ifid_instr=0, ifid_pc=0, ifid_npc=0, ifid_valid=0.
- Priority within each state: flush > stall > normal advance.
- State RUN:
  - flush && ihit: PC<=redirect_pc; IF/ID<=bubble; stay RUN.
  - flush && !ihit: pend_pc<=redirect_pc; IF/ID<=bubble; go DROP.
  - !flush && ihit && stall: PC and IF/ID hold. The returned word is discarded and refetched next cycle.
  - !flush && ihit && !stall: IF/ID<={iload, PC, PC+4, 1}; PC<=PC+4. If iload==HALT_WORD, go HALT with PC unchanged (PC is not incremented).
  - !flush && !ihit: everything holds; stall has no effect.
- State DROP (stale access in flight):
  - ihit && !flush: the returned word is discarded; PC<=pend_pc; go RUN; IF/ID stays bubble.
  - ihit && flush: PC<=redirect_pc (newest target wins); go RUN; IF/ID bubble.
  - !ihit && flush: pend_pc<=redirect_pc; stay DROP.
  - !ihit && !flush: hold.
  - stall is ignored in DROP.
- State HALT (no request outstanding):
  - flush: PC<=redirect_pc; IF/ID<=bubble; go RUN. This covers a halt that was fetched speculatively past a taken branch.
  - otherwise: PC and IF/ID hold, so the halt word remains in IF/ID for decode. ihit is ignored in HALT.
- One-cycle latency: a word accepted on edge N is visible on the ifid_* outputs after edge N.
- A normal advance never overwrites IF/ID in the same cycle as a flush.

Test Plan:
- Reset, then ihit=1 for 3 cycles with iload=A,B,C -> ifid_pc sequence 0,4,8 with instr A,B,C; ifid_npc=pc+4; valid=1; imemaddr=12 at end.
- Miss: imemaddr=0x10, ihit=0 for 4 cycles, then 1 with iload=X -> imemaddr stable at 0x10 throughout; IF/ID updates exactly once to {X,0x10,0x14,1}.
- Flush during miss: PC=0x20, ihit=0, flush with redirect_pc=0x100 -> state DROP, ifid_valid=0, imemaddr stays 0x20. A second flush to 0x200 before ihit, then ihit=1 -> PC=0x200, stale word never latched.
- ihit=1 with stall=1 at PC=0x40 -> PC stays 0x40, IF/ID unchanged. Same cycle with flush=1, redirect_pc=0x80 -> PC=0x80, bubble (flush wins).
- iload=HALT_WORD at PC=0x30 -> IF/ID holds {HALT_WORD,0x30,0x34,1}, imemREN=0, fetch_halted=1, PC frozen for 10 cycles. Then flush to 0x50 -> RUN, imemaddr=0x50, bubble.
- Assert RST during DROP -> outputs return to reset values immediately (asynchronously). After release, fetch starts at PC_INIT=0 and the old pend_pc is not used.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage and IF/ID pipeline latch: owns the PC, issues imem reads,
// absorbs redirects/stalls, and remembers a redirect that lands during an imem miss.
module if_fetch #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic        ifid_valid,
    output logic        fetch_halted
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_DROP = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = {redirect_pc[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        instr_d   = instr_q;
        ifpc_d    = ifpc_q;
        npc_d     = npc_q;
        valid_d   = valid_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    instr_d = '0;
                    ifpc_d  = '0;
                    npc_d   = '0;
                    valid_d = 1'b0;
                    // A miss in flight must complete before the new target can be issued.
                    if (ihit) begin
                        pc_d = target;
                    end else begin
                        pend_pc_d = target;
                        state_d   = ST_DROP;
                    end
                end else if (ihit && !stall) begin
                    instr_d = iload;
                    ifpc_d  = pc_q;
                    npc_d   = pc_plus4;
                    valid_d = 1'b1;
                    if (iload == HALT_WORD) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_DROP: begin
                if (ihit) begin
                    pc_d    = flush ? target : pend_pc_q;
                    state_d = ST_RUN;
                end else if (flush) begin
                    pend_pc_d = target;
                end
            end
            ST_HALT: begin
                if (flush) begin
                    pc_d    = target;
                    instr_d = '0;
                    ifpc_d  = '0;
                    npc_d   = '0;
                    valid_d = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_RUN;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
            instr_q   <= '0;
            ifpc_q    <= '0;
            npc_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            instr_q   <= instr_d;
            ifpc_q    <= ifpc_d;
            npc_q     <= npc_d;
            valid_q   <= valid_d;
        end
    end

    assign imemREN      = (state_q != ST_HALT) && !RST;
    assign imemaddr     = pc_q;
    assign ifid_instr   = instr_q;
    assign ifid_pc      = ifpc_q;
    assign ifid_npc     = npc_q;
    assign ifid_valid   = valid_q;
    assign fetch_halted = (state_q == ST_HALT);

endmodule
